// File: rtl/des_f_pipe_pkg.sv
// des_pkg: DES E/P tables, data typedefs and the table-driven bit permutation helper.
package des_pkg;
  typedef logic [31:0] half_t;
  typedef logic [47:0] subkey_t;
  typedef logic [47:0] exp_t;
  localparam logic [0:47][5:0] E_TABLE = {
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };
  localparam logic [0:31][5:0] P_TABLE = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };
  // P padded to the 48-entry shape des_permute takes; only the first 32 entries are used
  localparam logic [0:47][5:0] P_TABLE_48 = {P_TABLE, {16{6'd0}}};
  function automatic exp_t des_permute(input half_t src, input logic [0:47][5:0] tbl, input int n);
    exp_t r;
    r = '0;
    for (int i = 0; i < 48; i++)
      if (i < n) r[n-1-i] = src[32-int'(tbl[i])];
    return r;
  endfunction
endpackage

// File: rtl/des_f_pipe_if.sv
// des_f_pipe_if: input and output valid/ready channels of the DES f pipeline.
interface des_f_pipe_if
  import des_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic             in_valid, in_ready, out_valid, out_ready;
  half_t            r_half, f_out;
  subkey_t          subkey;
  logic [TAG_W-1:0] in_tag, out_tag;
  modport slave  (input in_valid, r_half, subkey, in_tag, out_ready, output in_ready, out_valid, f_out, out_tag);
  modport master (output in_valid, r_half, subkey, in_tag, out_ready, input in_ready, out_valid, f_out, out_tag);
endinterface

// File: rtl/des_f_pipe_sbox_bank.sv
// des_sbox_bank: splits the 48-bit expanded word into eight 6-bit chunks, MSB chunk to s_box1.
module des_sbox_bank
  import des_pkg::*;
(
  input  exp_t  x_i,
  output half_t s_o
);
  s_box1 u_s1 (.in_6bit(x_i[47:42]), .out_4bit(s_o[31:28]));
  s_box2 u_s2 (.in_6bit(x_i[41:36]), .out_4bit(s_o[27:24]));
  s_box3 u_s3 (.in_6bit(x_i[35:30]), .out_4bit(s_o[23:20]));
  s_box4 u_s4 (.in_6bit(x_i[29:24]), .out_4bit(s_o[19:16]));
  s_box5 u_s5 (.in_6bit(x_i[23:18]), .out_4bit(s_o[15:12]));
  s_box6 u_s6 (.in_6bit(x_i[17:12]), .out_4bit(s_o[11:8]));
  s_box7 u_s7 (.in_6bit(x_i[11:6]),  .out_4bit(s_o[7:4]));
  s_box8 u_s8 (.in_6bit(x_i[5:0]),   .out_4bit(s_o[3:0]));
endmodule

// File: rtl/des_s_boxes.sv
// s_box1..s_box8: DES S-boxes; row = {b5,b0}, column = b4..b1, table stored row-major.
module s_box1 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box2 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box3 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box4 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box5 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box6 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box7 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

module s_box8 (input logic [5:0] in_6bit, output logic [3:0] out_4bit);
  localparam logic [0:63][3:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  assign out_4bit = T[{in_6bit[5], in_6bit[0], in_6bit[4:1]}];
endmodule

// File: rtl/des_f_pipe.sv
// des_f_pipe: pipelined DES round function f(R,K) = P(S(E(R) ^ K)) with valid/ready on both sides.
// DES_F_OUT_REG_EN adds a third stage (S-boxes registered in S2, P registered in S3, latency 3).
module des_f_pipe
  import des_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  des_f_pipe_if.slave io,
  output logic        busy
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_adv, s2_adv, in_acc;
  exp_t             x_q, x_d;
  half_t            s_w, f_q, f_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  des_sbox_bank u_bank (.x_i(x_q), .s_o(s_w));
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign io.in_ready = s1_adv;
  assign in_acc      = io.in_valid && s1_adv;
  assign io.f_out    = f_q;
  always_comb begin
    s1_valid_d = s1_adv ? io.in_valid : s1_valid_q;
    x_d        = in_acc ? des_permute(io.r_half, E_TABLE, 48) ^ io.subkey : x_q;
    tag1_d     = in_acc ? io.in_tag : tag1_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      tag1_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      tag1_q     <= tag1_d;
    end
`ifdef DES_F_OUT_REG_EN
  logic             s3_valid_q, s3_valid_d, out_adv;
  half_t            s_q, s_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  assign out_adv = !s3_valid_q || io.out_ready;
  assign s2_adv  = !s2_valid_q || out_adv;
  always_comb begin
    s_d        = (s1_valid_q && s2_adv) ? s_w : s_q;
    tag2_d     = (s1_valid_q && s2_adv) ? tag1_q : tag2_q;
    s3_valid_d = out_adv ? s2_valid_q : s3_valid_q;
    f_d        = (s2_valid_q && out_adv) ? half_t'(des_permute(s_q, P_TABLE_48, 32)) : f_q;
    tag3_d     = (s2_valid_q && out_adv) ? tag2_q : tag3_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      s3_valid_q <= 1'b0;
      s_q        <= '0;
      tag2_q     <= '0;
      f_q        <= '0;
      tag3_q     <= '0;
    end else begin
      s3_valid_q <= s3_valid_d;
      s_q        <= s_d;
      tag2_q     <= tag2_d;
      f_q        <= f_d;
      tag3_q     <= tag3_d;
    end
  assign io.out_valid = s3_valid_q;
  assign io.out_tag   = tag3_q;
  assign busy         = s1_valid_q | s2_valid_q | s3_valid_q;
`else
  assign s2_adv = !s2_valid_q || io.out_ready;
  always_comb begin
    f_d    = (s1_valid_q && s2_adv) ? half_t'(des_permute(s_w, P_TABLE_48, 32)) : f_q;
    tag2_d = (s1_valid_q && s2_adv) ? tag1_q : tag2_q;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      f_q    <= '0;
      tag2_q <= '0;
    end else begin
      f_q    <= f_d;
      tag2_q <= tag2_d;
    end
  assign io.out_valid = s2_valid_q;
  assign io.out_tag   = tag2_q;
  assign busy         = s1_valid_q | s2_valid_q;
`endif
endmodule
